// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage of the 5-stage RV32I pipeline (EX/MEM -> WB).
// It turns an EX/MEM load/store packet into a registered request on the data-cache
// port. It holds the pipeline with stall_req until the cache answers, and then
// hands the raw load word plus its byte lanes to WB.
//
// Ports
//   clk, rst                : core clock, asynchronous active-low reset
//   in_valid, in_mem_read,
//   in_mem_write, in_funct3,
//   in_addr, in_rs2         : EX/MEM packet (address = alu_out, store source data)
//   load_buffers            : global pipeline advance from the hazard unit
//   dmem_address/read/write/
//   wmask/wdata             : registered cache request (word-aligned address)
//   dmem_rdata, dmem_resp   : cache response (one-cycle resp pulse)
//   mdrreg_out, rmask       : captured raw load word and its byte lanes, for WB
//   stall_req               : freeze request to the hazard unit
//   misaligned              : current access rejected as misaligned
//   mem_timeout             : sticky watchdog flag
//
// Parameter RESP_TIMEOUT: BUSY-cycle budget before the watchdog fires (0 = off).
// Optional build macro MEM_MISALIGN_CHECK_EN: when it is defined, misaligned
// halfword and word accesses are rejected without a request. Otherwise misaligned
// is tied to 0 and such accesses are issued with the shifted masks.
//
// state  | meaning
// S_IDLE | waiting for a memory op; a legal op stalls the pipe until it is issued
// S_BUSY | request on the cache port, waiting for dmem_resp or the watchdog
// S_DONE | access finished, results held until the pipeline advances
module mem_stage #(
  parameter int unsigned RESP_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_rs2,
  input  logic        load_buffers,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [31:0] mdrreg_out,
  output logic [3:0]  rmask,
  output logic        stall_req,
  output logic        misaligned,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic        op;
  logic [1:0]  off;
  logic [3:0]  acc_mask;
  logic        width_ok;
  logic [31:0] wdata_shift;
  logic        misalign_hit;

  logic        req_load_q;
  logic [3:0]  req_mask_q;
  logic [31:0] wait_cnt;
  logic [31:0] wait_cnt_inc;
  logic        timeout_hit;

  logic        issue;
  logic        resp_done;
  logic        fault_done;
  logic        misalign_take;

  // A packet with both read and write set is handled as a store.
  assign op  = in_valid && (in_mem_read || in_mem_write);
  assign off = in_addr[1:0];

  assign wdata_shift = in_rs2 << {off, 3'b000};

  always_comb begin
    acc_mask = 4'b0000;
    width_ok = 1'b0;
    case (in_funct3)
      3'b000, 3'b100: begin
        acc_mask = 4'b0001 << off;
        width_ok = 1'b1;
      end
      3'b001, 3'b101: begin
        acc_mask = 4'b0011 << {off[1], 1'b0};
        width_ok = 1'b1;
      end
      3'b010: begin
        acc_mask = 4'b1111;
        width_ok = 1'b1;
      end
      default: begin
        acc_mask = 4'b0000;
        width_ok = 1'b0;
      end
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign_hit = ((in_funct3[1:0] == 2'b01) && off[0]) ||
                        ((in_funct3 == 3'b010) && (off != 2'b00));
`else
  assign misalign_hit = 1'b0;
`endif

  // The counter holds the number of BUSY cycles already spent. It fires in the
  // cycle in which it would reach RESP_TIMEOUT. A response in that same cycle
  // still wins.
  assign wait_cnt_inc = wait_cnt + 32'd1;
  assign timeout_hit  = (RESP_TIMEOUT != 0) && (wait_cnt_inc == RESP_TIMEOUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    stall_req     = 1'b0;
    issue         = 1'b0;
    resp_done     = 1'b0;
    fault_done    = 1'b0;
    misalign_take = 1'b0;
    case (state)
      S_IDLE: begin
        // An unsupported funct3 produces no request. It must not stall either,
        // or the pipe would freeze forever.
        stall_req = op && width_ok;
        if (op && width_ok && !load_buffers) begin
          if (misalign_hit) begin
            misalign_take = 1'b1;
            state_next    = S_DONE;
          end else begin
            issue      = 1'b1;
            state_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stall_req = 1'b1;
        if (dmem_resp) begin
          resp_done  = 1'b1;
          state_next = S_DONE;
        end else if (timeout_hit) begin
          fault_done = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (load_buffers) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_address <= '0;
      dmem_read    <= 1'b0;
      dmem_write   <= 1'b0;
      dmem_wmask   <= '0;
      dmem_wdata   <= '0;
      mdrreg_out   <= '0;
      rmask        <= '0;
      mem_timeout  <= 1'b0;
      req_load_q   <= 1'b0;
      req_mask_q   <= '0;
      wait_cnt     <= '0;
    end else begin
      if (issue) begin
        dmem_address <= {in_addr[31:2], 2'b00};
        dmem_read    <= !in_mem_write;
        dmem_write   <= in_mem_write;
        dmem_wmask   <= in_mem_write ? acc_mask : 4'b0000;
        dmem_wdata   <= wdata_shift;
        req_load_q   <= !in_mem_write;
        req_mask_q   <= acc_mask;
        wait_cnt     <= '0;
      end

      if (state == S_BUSY) begin
        wait_cnt <= wait_cnt_inc;
      end

      if (resp_done || fault_done) begin
        dmem_read  <= 1'b0;
        dmem_write <= 1'b0;
      end

      // The load lanes are published only together with the captured data.
      // A completed store clears rmask and leaves the previous load word in place.
      if (resp_done) begin
        if (req_load_q) begin
          mdrreg_out <= dmem_rdata;
          rmask      <= req_mask_q;
        end else begin
          rmask <= 4'b0000;
        end
      end

      if (fault_done) begin
        mdrreg_out  <= '0;
        rmask       <= 4'b0000;
        mem_timeout <= 1'b1;
      end

      if (misalign_take) begin
        mdrreg_out <= '0;
        rmask      <= 4'b0000;
      end
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misaligned_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misaligned_q <= 1'b0;
    end else if (misalign_take) begin
      misaligned_q <= 1'b1;
    end else if ((state == S_DONE) && load_buffers) begin
      misaligned_q <= 1'b0;
    end
  end

  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_rs2;
  logic        load_buffers;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mdrreg_out;
  logic [3:0]  rmask;
  logic        stall_req;
  logic        misaligned;
  logic        mem_timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state that survives between transactions.
  logic [31:0] exp_mdr;
  logic [3:0]  exp_rmask;
  logic        exp_timeout;

  mem_stage #(.RESP_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_mem_read  (in_mem_read),
    .in_mem_write (in_mem_write),
    .in_funct3    (in_funct3),
    .in_addr      (in_addr),
    .in_rs2       (in_rs2),
    .load_buffers (load_buffers),
    .dmem_address (dmem_address),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .mdrreg_out   (mdrreg_out),
    .rmask        (rmask),
    .stall_req    (stall_req),
    .misaligned   (misaligned),
    .mem_timeout  (mem_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  // The access covers nb consecutive lanes, starting at the offset rounded down
  // to the access size (the low bits are dropped for halfwords).
  function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [1:0] off);
    int nb;
    int start;
    int lanes;
    nb    = ref_bytes(f3);
    start = (nb == 1) ? int'(off) : (nb == 2) ? (int'(off) / 2) * 2 : 0;
    lanes = ((1 << nb) - 1) << start;
    return lanes[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] rs2, input logic [1:0] off);
    logic [63:0] wide;
    wide = {32'd0, rs2} << (8 * int'(off));
    return wide[31:0];
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [1:0] off);
    int nb;
    nb = ref_bytes(f3);
    return (int'(off) % nb) != 0;
  endfunction

  // kind: 0 = load, 1 = store, 2 = read and write both set (handled as a store)
  task automatic run_txn(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input int lat, input logic [31:0] rdata,
                         input bit lb_hold);
    bit          st;
    bit          mis;
    logic [3:0]  m;
    int          busy_n;
    st  = (kind != 0);
    m   = ref_mask(f3, addr[1:0]);
    mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = ref_misaligned(f3, addr[1:0]);
`endif
    @(negedge clk);
    in_valid     = 1'b1;
    in_mem_read  = (kind != 1);
    in_mem_write = st;
    in_funct3    = f3;
    in_addr      = addr;
    in_rs2       = rs2;
    dmem_resp    = 1'b0;
    load_buffers = lb_hold;
    #1;
    check_val("stall_idle", {31'd0, stall_req}, 32'd1);
    if (lb_hold) begin
      @(negedge clk);
      load_buffers = 1'b0;
      #1;
      check_val("held_no_read", {31'd0, dmem_read}, 32'd0);
      check_val("held_no_write", {31'd0, dmem_write}, 32'd0);
      check_val("held_stall", {31'd0, stall_req}, 32'd1);
    end
    @(negedge clk);
    // The request is registered, so changing the packet now must not disturb it.
    in_addr   = $urandom;
    in_rs2    = $urandom;
    in_funct3 = 3'($urandom_range(0, 7));
    if (mis) begin
      in_valid = 1'b0;
      #1;
      check_val("mis_read", {31'd0, dmem_read}, 32'd0);
      check_val("mis_write", {31'd0, dmem_write}, 32'd0);
      exp_mdr   = 32'd0;
      exp_rmask = 4'd0;
    end else begin
      busy_n = (lat <= TO) ? lat : TO;
      for (int c = 1; c <= busy_n; c++) begin
        check_val("busy_read", {31'd0, dmem_read}, {31'd0, !st});
        check_val("busy_write", {31'd0, dmem_write}, {31'd0, st});
        check_val("busy_addr", dmem_address, {addr[31:2], 2'b00});
        check_val("busy_wmask", {28'd0, dmem_wmask}, {28'd0, (st ? m : 4'd0)});
        if (st) check_val("busy_wdata", dmem_wdata, ref_wdata(rs2, addr[1:0]));
        check_val("busy_stall", {31'd0, stall_req}, 32'd1);
        if (c == lat) begin
          dmem_resp  = 1'b1;
          dmem_rdata = rdata;
        end else begin
          dmem_rdata = $urandom;
        end
        @(negedge clk);
        dmem_resp = 1'b0;
      end
      if (lat <= TO) begin
        if (!st) begin
          exp_mdr   = rdata;
          exp_rmask = m;
        end else begin
          exp_rmask = 4'd0;
        end
      end else begin
        exp_timeout = 1'b1;
        exp_mdr     = 32'd0;
        exp_rmask   = 4'd0;
      end
      in_valid = 1'b0;
      #1;
    end
    check_val("done_read", {31'd0, dmem_read}, 32'd0);
    check_val("done_write", {31'd0, dmem_write}, 32'd0);
    check_val("done_stall", {31'd0, stall_req}, 32'd0);
    check_val("done_mdr", mdrreg_out, exp_mdr);
    check_val("done_rmask", {28'd0, rmask}, {28'd0, exp_rmask});
    check_val("done_timeout", {31'd0, mem_timeout}, {31'd0, exp_timeout});
    check_val("done_misaligned", {31'd0, misaligned}, {31'd0, mis});
    // A late or spurious response in DONE must be ignored.
    @(negedge clk);
    dmem_resp  = 1'b1;
    dmem_rdata = $urandom;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    check_val("done_stray_mdr", mdrreg_out, exp_mdr);
    check_val("done_hold_stall", {31'd0, stall_req}, 32'd0);
    load_buffers = 1'b1;
    @(negedge clk);
    load_buffers = 1'b0;
    #1;
    check_val("idle_stall", {31'd0, stall_req}, 32'd0);
    check_val("idle_misaligned", {31'd0, misaligned}, 32'd0);
    check_val("idle_read", {31'd0, dmem_read}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_addr"}, dmem_address, 32'd0);
    check_val({tag, "_read"}, {31'd0, dmem_read}, 32'd0);
    check_val({tag, "_write"}, {31'd0, dmem_write}, 32'd0);
    check_val({tag, "_wmask"}, {28'd0, dmem_wmask}, 32'd0);
    check_val({tag, "_wdata"}, dmem_wdata, 32'd0);
    check_val({tag, "_mdr"}, mdrreg_out, 32'd0);
    check_val({tag, "_rmask"}, {28'd0, rmask}, 32'd0);
    check_val({tag, "_misaligned"}, {31'd0, misaligned}, 32'd0);
    check_val({tag, "_timeout"}, {31'd0, mem_timeout}, 32'd0);
    check_val({tag, "_stall"}, {31'd0, stall_req}, 32'd0);
  endtask

  initial begin
    int          kind;
    logic [2:0]  f3;
    logic [31:0] a;
    rst          = 1'b0;
    in_valid     = 1'b0;
    in_mem_read  = 1'b0;
    in_mem_write = 1'b0;
    in_funct3    = 3'd0;
    in_addr      = 32'd0;
    in_rs2       = 32'd0;
    load_buffers = 1'b0;
    dmem_rdata   = 32'd0;
    dmem_resp    = 1'b0;
    exp_mdr      = 32'd0;
    exp_rmask    = 4'd0;
    exp_timeout  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // LW 0x1004, response in the third BUSY cycle
    run_txn(0, 3'b010, 32'h0000_1004, 32'd0, 3, 32'hCAFE_BABE, 1'b0);
    // SB 0xA5 to 0x2003
    run_txn(1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 2, 32'd0, 1'b0);
    // SH 0x1234 to 0x2002, response in the first BUSY cycle
    run_txn(1, 3'b001, 32'h0000_2002, 32'h0000_1234, 1, 32'd0, 1'b0);
    // LBU with the hazard unit holding the packet back for one cycle
    run_txn(0, 3'b100, 32'h0000_3001, 32'd0, 2, 32'h1122_3344, 1'b1);
    // No response: the watchdog fires after TO BUSY cycles, and the flag persists
    run_txn(0, 3'b010, 32'h0000_4000, 32'd0, 10, 32'h0BAD_0BAD, 1'b0);
    run_txn(0, 3'b010, 32'h0000_4004, 32'd0, 2, 32'h5566_7788, 1'b0);
`ifdef MEM_MISALIGN_CHECK_EN
    run_txn(0, 3'b010, 32'h0000_1001, 32'd0, 1, 32'h1234_5678, 1'b0);
`endif

    // Reset in the middle of BUSY clears everything at once
    @(negedge clk);
    in_valid     = 1'b1;
    in_mem_read  = 1'b1;
    in_mem_write = 1'b0;
    in_funct3    = 3'b010;
    in_addr      = 32'h0000_5008;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_val("pre_rst_read", {31'd0, dmem_read}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst         = 1'b1;
    exp_mdr     = 32'd0;
    exp_rmask   = 4'd0;
    exp_timeout = 1'b0;

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 2));
      end
      a = $urandom;
      run_txn(kind, f3, a, $urandom, $urandom_range(1, 6), $urandom, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) begin
        // A response while IDLE must not be captured.
        @(negedge clk);
        dmem_resp  = 1'b1;
        dmem_rdata = $urandom;
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        check_val("idle_stray_mdr", mdrreg_out, exp_mdr);
        check_val("idle_stray_read", {31'd0, dmem_read}, 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
